// File: rtl/difftest_commit_drain.sv
// difftest_commit_drain: buffers commit bundles and serializes them into one record per handshake
module difftest_commit_drain #(
  parameter int CONFIG_DW = 32,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_P_FIFO_DEPTH = 3,
  parameter int PC_W = 30,
  parameter int INSN_DW = 32,
  parameter int LRF_AW = 5,
  localparam int CW = 1 << CONFIG_P_COMMIT_WIDTH,
  localparam int AW = CONFIG_P_FIFO_DEPTH,
  localparam int D = 1 << CONFIG_P_FIFO_DEPTH,
  localparam int LW = CONFIG_P_COMMIT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CW-1:0]           in_valid,
  input  logic [PC_W*CW-1:0]      in_pc,
  input  logic [INSN_DW*CW-1:0]   in_insn,
  input  logic [CW-1:0]           in_wen,
  input  logic [LRF_AW*CW-1:0]    in_wnum,
  input  logic [CONFIG_DW*CW-1:0] in_wdata,
  input  logic                    in_excp,
  input  logic [31:0]             in_excp_vect,
  input  logic                    clr_ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PC_W-1:0]         out_pc,
  output logic [INSN_DW-1:0]      out_insn,
  output logic                    out_wen,
  output logic [LRF_AW-1:0]       out_wnum,
  output logic [CONFIG_DW-1:0]    out_wdata,
  output logic [LW-1:0]           out_lane,
  output logic                    out_last,
  output logic                    out_excp,
  output logic [31:0]             out_excp_vect,
  output logic [31:0]             out_seq,
  output logic                    ovf,
  output logic [15:0]             drop_cnt,
  output logic [AW:0]             fifo_level
);
  typedef enum logic [1:0] {EMPTY, LOAD, EMIT} state_t;
  state_t state;
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic [CW-1:0] mask, low;
  logic [LW-1:0] lane;
  logic [CW-1:0] mem_mask [D];
  logic [CW-1:0] mem_wen [D];
  logic [PC_W*CW-1:0] mem_pc [D];
  logic [INSN_DW*CW-1:0] mem_insn [D];
  logic [LRF_AW*CW-1:0] mem_wnum [D];
  logic [CONFIG_DW*CW-1:0] mem_wdata [D];
  logic mem_excp [D];
  logic [31:0] mem_vect [D];
  logic [PC_W*CW-1:0] h_pc;
  logic [INSN_DW*CW-1:0] h_insn;
  logic [LRF_AW*CW-1:0] h_wnum;
  logic [CONFIG_DW*CW-1:0] h_wdata;
  logic [CW-1:0] h_wen;
  logic [AW-1:0] ra, wa;
  logic push_q, full, empty, hs, last, pop, accept, drop;
  assign ra = rptr[AW-1:0];
  assign wa = wptr[AW-1:0];
  assign push_q = |in_valid || in_excp;
  assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign empty = wptr == rptr;
  assign out_valid = state == EMIT;
  assign hs = out_valid && out_ready;
  assign last = mask != '0 && (mask & (mask - CW'(1))) == '0;
  assign pop = hs && last;
  assign accept = push_q && (!full || pop);
  assign drop = push_q && full && !pop;
  assign wptr_n = wptr + {{AW{1'b0}}, accept};
  assign rptr_n = rptr + {{AW{1'b0}}, pop};
  assign low = mask & (~mask + CW'(1));
  assign fifo_level = wptr - rptr;
  assign h_pc = mem_pc[ra];
  assign h_insn = mem_insn[ra];
  assign h_wnum = mem_wnum[ra];
  assign h_wdata = mem_wdata[ra];
  assign h_wen = mem_wen[ra];
  // lowest pending lane is the record currently shown
  always_comb begin
    lane = '0;
    for (int i = CW - 1; i >= 0; i--)
      if (mask[i]) lane = LW'(i);
  end
  assign out_pc = out_valid ? h_pc[lane*PC_W +: PC_W] : '0;
  assign out_insn = out_valid ? h_insn[lane*INSN_DW +: INSN_DW] : '0;
  assign out_wnum = out_valid ? h_wnum[lane*LRF_AW +: LRF_AW] : '0;
  assign out_wdata = out_valid ? h_wdata[lane*CONFIG_DW +: CONFIG_DW] : '0;
  assign out_wen = out_valid && h_wen[lane];
  assign out_lane = out_valid ? lane : '0;
  assign out_last = out_valid && last;
  assign out_excp = out_last && mem_excp[ra];
  assign out_excp_vect = out_excp ? mem_vect[ra] : '0;
  // bundle storage; exception-only bundles get a lane-0 mask with write enable suppressed
  always_ff @(posedge clk)
    if (accept) begin
      mem_mask[wa] <= |in_valid ? in_valid : CW'(1);
      mem_wen[wa] <= in_wen & in_valid;
      mem_pc[wa] <= in_pc;
      mem_insn[wa] <= in_insn;
      mem_wnum[wa] <= in_wnum;
      mem_wdata[wa] <= in_wdata;
      mem_excp[wa] <= in_excp;
      mem_vect[wa] <= in_excp_vect;
    end
  // pointers, sequence counter and serializer state machine
  always_ff @(posedge clk)
    if (!rst) begin
      state <= EMPTY;
      mask <= '0;
      wptr <= '0;
      rptr <= '0;
      out_seq <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      if (hs) out_seq <= out_seq + 32'd1;
      case (state)
        EMPTY: if (!empty) state <= LOAD;
        LOAD: begin
          mask <= mem_mask[ra];
          state <= EMIT;
        end
        default: if (hs) begin
          mask <= mask & ~low;
          if (last) state <= (wptr_n != rptr_n) ? LOAD : EMPTY;
        end
      endcase
    end
  // sticky overflow and saturating drop counter; a drop beats a concurrent clear
  always_ff @(posedge clk)
    if (!rst) begin
      ovf <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ovf <= drop ? 1'b1 : clr_ovf ? 1'b0 : ovf;
      drop_cnt <= drop ? (clr_ovf ? 16'd1 : drop_cnt + {15'd0, drop_cnt != 16'hFFFF}) : clr_ovf ? 16'd0 : drop_cnt;
    end
endmodule

// File: tb/tb_difftest_commit_drain.sv
// tb_difftest_commit_drain: directed table, corner sequences and randomized model check
module tb_difftest_commit_drain;
  localparam int P = 1, CW = 2, FD = 3, D = 8, DW = 32, PCW = 30, IW = 32, AW = 5;
  logic clk = 0, rst = 0;
  logic [CW-1:0] in_valid, in_wen;
  logic [PCW*CW-1:0] in_pc;
  logic [IW*CW-1:0] in_insn;
  logic [AW*CW-1:0] in_wnum;
  logic [DW*CW-1:0] in_wdata;
  logic in_excp, clr_ovf, out_valid, out_ready, out_wen, out_last, out_excp, ovf;
  logic [31:0] in_excp_vect, out_excp_vect, out_seq, out_insn, out_wdata;
  logic [PCW-1:0] out_pc;
  logic [AW-1:0] out_wnum;
  logic [P-1:0] out_lane;
  logic [15:0] drop_cnt;
  logic [FD:0] fifo_level;
  int checks = 0, errors = 0;

  difftest_commit_drain #(.CONFIG_DW(DW), .CONFIG_P_COMMIT_WIDTH(P), .CONFIG_P_FIFO_DEPTH(FD),
    .PC_W(PCW), .INSN_DW(IW), .LRF_AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn), .in_wen(in_wen),
    .in_wnum(in_wnum), .in_wdata(in_wdata), .in_excp(in_excp), .in_excp_vect(in_excp_vect),
    .clr_ovf(clr_ovf), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_insn(out_insn), .out_wen(out_wen), .out_wnum(out_wnum), .out_wdata(out_wdata),
    .out_lane(out_lane), .out_last(out_last), .out_excp(out_excp), .out_excp_vect(out_excp_vect),
    .out_seq(out_seq), .ovf(ovf), .drop_cnt(drop_cnt), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] v, w;
    logic e;
    logic [31:0] vect;
    logic [PCW-1:0] base;
    int n;
    logic [P-1:0] lane0;
    logic wen0;
    logic excp_fin;
    logic [31:0] vect_fin;
  } vec_t;

  typedef struct {
    logic [PCW-1:0] pc;
    logic [IW-1:0] insn;
    logic wen;
    logic [AW-1:0] wnum;
    logic [DW-1:0] wdata;
    logic [P-1:0] lane;
    logic last, excp;
    logic [31:0] vect;
  } rec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    in_valid = '0; in_wen = '0; in_excp = 0; in_excp_vect = '0; clr_ovf = 0;
    in_pc = '0; in_insn = '0; in_wnum = '0; in_wdata = '0;
  endtask

  task automatic set_bundle(input logic [CW-1:0] v, input logic [CW-1:0] w, input logic e,
                            input logic [31:0] vect, input logic [PCW-1:0] base);
    in_valid = v; in_wen = w; in_excp = e; in_excp_vect = vect;
    for (int i = 0; i < CW; i++) begin
      in_pc[i*PCW +: PCW] = base + PCW'(i);
      in_insn[i*IW +: IW] = 32'hA000 + 32'(i);
      in_wnum[i*AW +: AW] = AW'(i + 3);
      in_wdata[i*DW +: DW] = 32'hD000 + 32'(i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; idle_in();
    @(negedge clk);
    rst = 1;
  endtask

  vec_t tbl[4];
  rec_t q[$];
  rec_t r;
  int exp_seq, cnt, got;
  logic [PCW-1:0] drain_pc[9];
  logic [CW-1:0] rv;
  logic re, rdy, pushq, hs, pop, mclr;
  logic [31:0] rvect, mseq;
  int mlvl, stall;
  logic movf;
  logic [15:0] mdrop;

  initial begin
    tbl[0] = '{2'b11, 2'b11, 1'b0, 32'h0,  30'h100, 2, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{2'b10, 2'b10, 1'b1, 32'h80, 30'h100, 1, 1'b1, 1'b1, 1'b1, 32'h80};
    tbl[2] = '{2'b00, 2'b11, 1'b1, 32'h44, 30'h300, 1, 1'b0, 1'b0, 1'b1, 32'h44};
    tbl[3] = '{2'b01, 2'b01, 1'b0, 32'h0,  30'h400, 1, 1'b0, 1'b1, 1'b0, 32'h0};
    idle_in(); out_ready = 1;
    do_reset();
    chk("rst_valid", out_valid, 0); chk("rst_seq", out_seq, 0); chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop_cnt, 0); chk("rst_level", fifo_level, 0); chk("rst_pc", out_pc, 0);

    exp_seq = 0;
    foreach (tbl[k]) begin
      @(negedge clk);
      set_bundle(tbl[k].v, tbl[k].w, tbl[k].e, tbl[k].vect, tbl[k].base);
      @(negedge clk);
      idle_in();
      chk("valid_n", out_valid, 0);
      @(negedge clk);
      chk("valid_n1", out_valid, 0);
      @(negedge clk);
      chk("valid_n2", out_valid, 1);
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
        if (c > 0) @(negedge clk);
        if (out_valid) begin
          chk("tbl_lane", out_lane, cnt == 0 ? tbl[k].lane0 : P'(1));
          chk("tbl_pc", out_pc, tbl[k].base + (cnt == 0 ? PCW'(tbl[k].lane0) : PCW'(1)));
          chk("tbl_seq", out_seq, exp_seq);
          chk("tbl_last", out_last, cnt == tbl[k].n - 1);
          if (cnt == 0) chk("tbl_wen", out_wen, tbl[k].wen0);
          if (out_last) begin
            chk("tbl_excp", out_excp, tbl[k].excp_fin);
            chk("tbl_vect", out_excp_vect, tbl[k].vect_fin);
          end else chk("tbl_excp_mid", {out_excp, out_excp_vect}, 0);
          exp_seq++;
          cnt++;
        end
      end
      chk("tbl_nrec", cnt, tbl[k].n);
    end

    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_bundle(2'b01, 2'b01, 0, 0, 30'h500 + 30'(k));
    end
    @(negedge clk); idle_in();
    @(negedge clk); @(negedge clk);
    chk("pre_rst_level", fifo_level, 3);
    chk("pre_rst_valid", out_valid, 1);
    do_reset();
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0); chk("post_rst_level", fifo_level, 0);
    chk("post_rst_seq", out_seq, 0);
    @(negedge clk);
    chk("post_rst_valid2", out_valid, 0);

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("bp_pc_stable", out_pc, 30'h200);
        chk("bp_seq_stable", out_seq, 0);
      end
      set_bundle(2'b01, 2'b01, 0, 0, 30'h200 + 30'(k));
    end
    @(negedge clk); idle_in();
    chk("ovf_level", fifo_level, 8); chk("ovf_flag", ovf, 1); chk("ovf_drop", drop_cnt, 2);
    @(negedge clk);
    chk("bp_valid", out_valid, 1); chk("bp_pc", out_pc, 30'h200);
    chk("bp_seq", out_seq, 0); chk("bp_last", out_last, 1);
    out_ready = 1;
    set_bundle(2'b01, 2'b01, 0, 0, 30'h20A);
    @(negedge clk); idle_in();
    chk("fp_level", fifo_level, 8); chk("fp_drop", drop_cnt, 2);
    for (int k = 0; k < 7; k++) drain_pc[k] = 30'h201 + 30'(k);
    drain_pc[7] = 30'h20A;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) begin
        chk("drain_pc", out_pc, drain_pc[got]);
        chk("drain_seq", out_seq, got + 1);
        got++;
      end
    end
    chk("drain_count", got, 8);
    @(negedge clk);
    chk("drain_level", fifo_level, 0);

    out_ready = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      set_bundle(2'b11, 2'b00, 0, 0, 30'h600 + 30'(2 * k));
    end
    @(negedge clk); idle_in();
    chk("clr_pre_drop", drop_cnt, 3); chk("clr_pre_level", fifo_level, 8);
    set_bundle(2'b01, 2'b01, 0, 0, 30'h700); clr_ovf = 1;
    @(negedge clk); idle_in();
    chk("clr_drop_ovf", ovf, 1); chk("clr_drop_cnt", drop_cnt, 1);
    clr_ovf = 1;
    @(negedge clk); idle_in();
    chk("clr_ovf", ovf, 0); chk("clr_cnt", drop_cnt, 0);

    do_reset();
    q.delete(); mlvl = 0; mseq = 0; movf = 0; mdrop = 0; stall = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_level", fifo_level, mlvl);
      chk("rnd_ovf", ovf, movf);
      chk("rnd_drop", drop_cnt, mdrop);
      if (out_valid) begin
        stall = 0;
        if (q.size() == 0) chk("rnd_spurious", out_valid, 0);
        else begin
          chk("rnd_pc", out_pc, q[0].pc);
          chk("rnd_insn", out_insn, q[0].insn);
          chk("rnd_wdata", out_wdata, q[0].wdata);
          chk("rnd_ctl", {out_wen, out_wnum, out_lane, out_last, out_excp},
              {q[0].wen, q[0].wnum, q[0].lane, q[0].last, q[0].excp});
          chk("rnd_vect", out_excp_vect, q[0].vect);
          chk("rnd_seq", out_seq, mseq);
        end
      end else begin
        chk("rnd_idle_zero", {out_pc, out_wen, out_last, out_excp, out_lane, out_excp_vect}, 0);
        if (q.size() > 0) begin
          stall++;
          chk("rnd_stall", stall <= 3, 1);
        end
      end
      rdy = (cyc % 400 < 120) ? 1'b0 : ($urandom_range(0, 9) < 6);
      rv = $urandom_range(0, 1) ? CW'($urandom) : '0;
      re = $urandom_range(0, 3) == 0;
      rvect = $urandom;
      mclr = $urandom_range(0, 49) == 0;
      out_ready = rdy; clr_ovf = mclr;
      in_valid = rv; in_excp = re; in_excp_vect = rvect; in_wen = CW'($urandom);
      for (int i = 0; i < CW; i++) begin
        in_pc[i*PCW +: PCW] = PCW'($urandom);
        in_insn[i*IW +: IW] = $urandom;
        in_wnum[i*AW +: AW] = AW'($urandom);
        in_wdata[i*DW +: DW] = $urandom;
      end
      hs = out_valid && rdy && q.size() > 0;
      pop = hs && q[0].last;
      if (hs) begin
        void'(q.pop_front());
        mseq = mseq + 1;
      end
      pushq = |rv || re;
      if (pushq && (mlvl < D || pop)) begin
        for (int i = 0; i < CW; i++)
          if (rv[i] || (rv == 0 && i == 0)) begin
            r.pc = in_pc[i*PCW +: PCW]; r.insn = in_insn[i*IW +: IW];
            r.wen = rv != 0 && in_wen[i]; r.wnum = in_wnum[i*AW +: AW];
            r.wdata = in_wdata[i*DW +: DW]; r.lane = P'(i);
            r.last = (rv >> (i + 1)) == 0;
            r.excp = r.last && re; r.vect = r.excp ? rvect : 0;
            q.push_back(r);
          end
        mlvl++;
        if (mclr) begin movf = 0; mdrop = 0; end
      end else if (pushq) begin
        movf = 1;
        mdrop = mclr ? 16'd1 : (mdrop == 16'hFFFF ? mdrop : mdrop + 1);
      end else if (mclr) begin
        movf = 0; mdrop = 0;
      end
      if (pop) mlvl--;
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
